matrix_mul_stream: RTL

MATRIX_MUL_STREAM -- requirements
Module: matrix_mul_stream

---
 rtl/matrix_mul_stream.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/matrix_mul_stream.sv
// Streaming matrix multiplier: loads A (MxK) and B (KxN) row-major, then emits C = A*B
// row-major, LANES columns per compute group. Optional C saturation via MATMUL_STREAM_SAT_EN.
module matrix_mul_stream #(
  parameter int M      = 2,
  parameter int K      = 2,
  parameter int N      = 2,
  parameter int DATA_W = 16,
  parameter int ACC_W  = 40,
  parameter int OUT_W  = 32,
  parameter int LANES  = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  input  logic              a_valid,
  output logic              a_ready,
  input  logic [DATA_W-1:0] a_data,
  input  logic              b_valid,
  output logic              b_ready,
  input  logic [DATA_W-1:0] b_data,
  output logic              c_valid,
  input  logic              c_ready,
  output logic [OUT_W-1:0]  c_data,
  output logic              c_last
);

  localparam int G   = N / LANES;
  localparam int A_D = M * K;
  localparam int B_D = K * N;
  localparam int ACW = $clog2(A_D + 1);
  localparam int BCW = $clog2(B_D + 1);
  localparam int AIW = (A_D > 1) ? $clog2(A_D) : 1;
  localparam int BIW = (B_D > 1) ? $clog2(B_D) : 1;
  localparam int RW  = (M > 1) ? $clog2(M) : 1;
  localparam int KW  = (K > 1) ? $clog2(K) : 1;
  localparam int GW  = (G > 1) ? $clog2(G) : 1;
  localparam int LW  = (LANES > 1) ? $clog2(LANES) : 1;

  typedef enum logic [2:0] {IDLE, LOAD, COMPUTE, DRAIN, FINISH} state_t;

  state_t state, state_next;

  logic [ACW-1:0] a_cnt;
  logic [BCW-1:0] b_cnt;
  logic [RW-1:0]  row;
  logic [KW-1:0]  kk;
  logic [GW-1:0]  grp;
  logic [LW-1:0]  lane;

  logic signed [DATA_W-1:0]   a_buf [A_D];
  logic signed [DATA_W-1:0]   b_buf [B_D];
  logic signed [ACC_W-1:0]    acc   [LANES];
  logic signed [2*DATA_W-1:0] prod  [LANES];
  logic signed [DATA_W-1:0]   a_op;
  logic [OUT_W-1:0]           result;

  logic a_full, b_full, k_last, row_last, grp_last, lane_last;

  assign a_full    = (a_cnt == ACW'(A_D));
  assign b_full    = (b_cnt == BCW'(B_D));
  assign k_last    = (kk == KW'(K - 1));
  assign row_last  = (row == RW'(M - 1));
  assign grp_last  = (grp == GW'(G - 1));
  assign lane_last = (lane == LW'(LANES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    busy       = 1'b1;
    done       = 1'b0;
    a_ready    = 1'b0;
    b_ready    = 1'b0;
    c_valid    = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) state_next = LOAD;
      end
      LOAD: begin
        a_ready = !a_full;
        b_ready = !b_full;
        if (a_full && b_full) state_next = COMPUTE;
      end
      COMPUTE: begin
        if (k_last) state_next = DRAIN;
      end
      DRAIN: begin
        c_valid = 1'b1;
        if (c_ready && lane_last)
          state_next = (row_last && grp_last) ? FINISH : COMPUTE;
      end
      FINISH: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // One A element is shared by all lanes; each lane reads its own B column.
  always_comb begin
    a_op = a_buf[AIW'(int'(row) * K + int'(kk))];
    for (int unsigned l = 0; l < LANES; l++)
      prod[l] = a_op * b_buf[BIW'(int'(kk) * N + int'(grp) * LANES + int'(l))];
  end

  always_ff @(posedge clk) begin
    if (state == LOAD && a_valid && a_ready) a_buf[a_cnt[AIW-1:0]] <= a_data;
    if (state == LOAD && b_valid && b_ready) b_buf[b_cnt[BIW-1:0]] <= b_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_cnt <= '0;
      b_cnt <= '0;
      row   <= '0;
      kk    <= '0;
      grp   <= '0;
      lane  <= '0;
      for (int unsigned l = 0; l < LANES; l++) acc[l] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_cnt <= '0;
            b_cnt <= '0;
            row   <= '0;
            kk    <= '0;
            grp   <= '0;
            lane  <= '0;
          end
        end
        LOAD: begin
          if (a_valid && a_ready) a_cnt <= a_cnt + 1'b1;
          if (b_valid && b_ready) b_cnt <= b_cnt + 1'b1;
        end
        COMPUTE: begin
          // k==0 overwrites instead of adding, which clears the group's sums on entry.
          for (int unsigned l = 0; l < LANES; l++)
            acc[l] <= ((kk == '0) ? '0 : acc[l]) + ACC_W'(prod[l]);
          kk <= k_last ? '0 : kk + 1'b1;
        end
        DRAIN: begin
          if (c_ready) begin
            if (lane_last) begin
              lane <= '0;
              if (grp_last) begin
                grp <= '0;
                row <= row_last ? '0 : row + 1'b1;
              end else begin
                grp <= grp + 1'b1;
              end
            end else begin
              lane <= lane + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

`ifdef MATMUL_STREAM_SAT_EN
  logic [ACC_W-OUT_W:0] upper;
  always_comb begin
    upper = acc[lane][ACC_W-1:OUT_W-1];
    if (upper == '0 || upper == '1) result = acc[lane][OUT_W-1:0];
    else if (upper[ACC_W-OUT_W])    result = {1'b1, {(OUT_W-1){1'b0}}};
    else                            result = {1'b0, {(OUT_W-1){1'b1}}};
  end
`else
  assign result = acc[lane][OUT_W-1:0];
`endif

  assign c_data = (state == DRAIN) ? result : '0;
  assign c_last = (state == DRAIN) && row_last && grp_last && lane_last;

endmodule
